// File: rtl/data_mem_responder.sv
// Load/store responder: serves byte/half/word accesses from a word-organised RAM with lane writes and load extension.
// Latency: a request sampled in IDLE gives a one-cycle ready pulse WAIT_CYCLES+2 cycles after the accepting edge's cycle.
// Backpressure: none queued; req is ignored while busy=1, requester holds or re-issues req until ready.
// Optional DMEM_ACCESS_CHECK_EN: enables misalignment / illegal-func3 detection on err; otherwise err=0 and accesses are forced aligned.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    localparam int         WAIT_LAST_INT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] WAIT_LAST     = 4'(WAIT_LAST_INT);

    state_t                  state, state_nxt;
    logic [3:0]              wait_cnt;
    logic                    we_q;
    logic [2:0]              f3_q;
    logic [ADDR_WIDTH+1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic [31:0]             mem [2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    legal;
    logic [1:0]              size_code;
    logic [1:0]              off;
    logic                    bad;
    logic [31:0]             cur_word;
    logic [3:0]              byte_en;
    logic [31:0]             wlanes;
    logic [7:0]              sel_byte;
    logic [15:0]             sel_half;
    logic [31:0]             load_val;

    // Upper address bits only select aliases of the same RAM word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

    assign word_idx = addr_q[ADDR_WIDTH+1:2];

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Wait-state counter: runs 0..WAIT_CYCLES-1 while in WAIT, zero elsewhere
    always_ff @(posedge clk) begin
        if (!reset)                                   wait_cnt <= 4'd0;
        else if (state == S_WAIT && wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + 4'd1;
        else                                          wait_cnt <= 4'd0;
    end

    // Capture the request fields on acceptance
    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else if (state == S_IDLE && req) begin
            we_q    <= we;
            f3_q    <= func3;
            addr_q  <= addr[ADDR_WIDTH+1:0];
            wdata_q <= wdata;
        end
    end

    // Decode access size, effective lane offset and access legality
    always_comb begin
        legal     = (f3_q[1:0] != 2'b11) && !(f3_q[2] && (f3_q[1] || we_q));
        size_code = legal ? f3_q[1:0] : 2'b10;
        off       = addr_q[1:0];
        bad       = 1'b0;
`ifdef DMEM_ACCESS_CHECK_EN
        if (!legal)                                   bad = 1'b1;
        else if (size_code == 2'b01 && addr_q[0])     bad = 1'b1;
        else if (size_code == 2'b10 && addr_q[1:0] != 2'b00) bad = 1'b1;
`else
        if (size_code == 2'b01)      off = {addr_q[1], 1'b0};
        else if (size_code == 2'b10) off = 2'b00;
`endif
    end

    // Byte-lane enables, replicated store data and extended load value
    always_comb begin
        cur_word = mem[word_idx];
        byte_en  = 4'b1111;
        wlanes   = wdata_q;
        sel_byte = cur_word[{off, 3'b000} +: 8];
        sel_half = off[1] ? cur_word[31:16] : cur_word[15:0];
        load_val = cur_word;
        case (size_code)
            2'b00: begin
                byte_en  = 4'b0001 << off;
                wlanes   = {4{wdata_q[7:0]}};
                load_val = f3_q[2] ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            end
            2'b01: begin
                byte_en  = off[1] ? 4'b1100 : 4'b0011;
                wlanes   = {2{wdata_q[15:0]}};
                load_val = f3_q[2] ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
            end
            default: ;
        endcase
    end

    // RAM write on the edge leaving ACCESS; contents survive reset
    always_ff @(posedge clk) begin
        if (reset && state == S_ACCESS && we_q && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

`ifdef DMEM_ACCESS_CHECK_EN
    logic err_q;

    // Register the access error flag on the edge leaving ACCESS
    always_ff @(posedge clk) begin
        if (!reset)                err_q <= 1'b0;
        else if (state == S_ACCESS) err_q <= bad;
    end
`endif

    // Register load data on the edge leaving ACCESS; stores keep the last value
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= 32'd0;
        end else if (state == S_ACCESS) begin
            if (bad)        rdata_q <= 32'd0;
            else if (!we_q) rdata_q <= load_val;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
            S_WAIT:   if (wait_cnt == WAIT_LAST) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs: ready/busy from state, err only qualified by ready
    always_comb begin
        ready = (state == S_RESP);
        busy  = (state != S_IDLE);
        rdata = rdata_q;
`ifdef DMEM_ACCESS_CHECK_EN
        err   = (state == S_RESP) && err_q;
`else
        err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized accesses against a byte-array model.
// Latency: each transaction waits for ready with a bounded cycle count.
// Backpressure: requests are issued only when the responder is idle, except where busy behaviour is probed.
module tb_data_mem_responder;

    localparam int AW = 8;
    localparam int WC = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [1024];

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .func3(func3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference: RAM seen as 1024 bytes; sizes 1/2/4 bytes, little-endian.
    function automatic void model_op(input logic w, input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] wd, output logic [31:0] rd, output logic e);
        int unsigned size, base;
        bit legal;
        logic [31:0] v;
        if (w) legal = (f <= 3'd2);
        else   legal = (f <= 3'd2) || (f == 3'd4) || (f == 3'd5);
        size = 1 << f[1:0];
        rd = 32'd0;
        e  = 1'b0;
`ifdef DMEM_ACCESS_CHECK_EN
        if (!legal || (a % size) != 0) begin
            e = 1'b1;
            return;
        end
`endif
        if (!legal) size = 4;
        base = (a % 1024) - (a % size);
        if (w) begin
            for (int i = 0; i < int'(size); i++) mb[base + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < int'(size); i++) v = v | (32'(mb[base + i]) << (8*i));
            if (size < 4 && f[2] == 1'b0 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            rd = v;
        end
    endfunction

    // Issue one request from idle and wait (bounded) for its ready pulse.
    task automatic run_txn(input logic w, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output logic e,
                           output int lat);
        @(negedge clk);
        req = 1'b1; we = w; func3 = f; addr = a; wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        while (!ready && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        rd = rdata;
        e  = err;
        if (!ready) lat = -1;
    endtask

    task automatic test_reset();
        logic [31:0] rd, mrd;
        logic e, me;
        int lat;
        req = 1'b1; we = 1'b1; func3 = 3'b010; addr = 32'h10; wdata = 32'h5555_5555;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ready !== 1'b0 || busy !== 1'b0 || rdata !== 32'd0 || err !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: ready=%b busy=%b rdata=%h err=%b, required 0 0 00000000 0",
                         ready, busy, rdata, err);
            end
        end
        reset = 1'b1;
        req = 1'b0;
        run_txn(1'b1, 3'b010, 32'h3C, 32'h0102_0304, rd, e, lat);
        model_op(1'b1, 3'b010, 32'h3C, 32'h0102_0304, mrd, me);
        checks++;
        if (lat !== WC + 2 || e !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_txn: latency=%0d err=%b, required latency=%0d err=0", lat, e, WC + 2);
        end
    endtask

    task automatic test_sw_lw();
        logic [31:0] rd, mrd;
        logic e, me;
        int lat;
        run_txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, e, lat);
        model_op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, mrd, me);
        checks++;
        if (lat !== WC + 2) begin
            errors++;
            $display("FAIL sw_latency: got %0d, required %0d", lat, WC + 2);
        end
        run_txn(1'b0, 3'b010, 32'h10, 32'd0, rd, e, lat);
        model_op(1'b0, 3'b010, 32'h10, 32'd0, mrd, me);
        checks++;
        if (lat !== WC + 2) begin
            errors++;
            $display("FAIL lw_latency: got %0d, required %0d", lat, WC + 2);
        end
        checks++;
        if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL lw_data: got %h err=%b, required deadbeef err=0", rd, e);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, mrd;
        logic e, me;
        int lat;
        run_txn(1'b1, 3'b000, 32'h12, 32'h1234_56A5, rd, e, lat);
        model_op(1'b1, 3'b000, 32'h12, 32'h1234_56A5, mrd, me);
        run_txn(1'b0, 3'b010, 32'h10, 32'd0, rd, e, lat);
        model_op(1'b0, 3'b010, 32'h10, 32'd0, mrd, me);
        checks++;
        if (rd !== 32'hDEA5_BEEF) begin
            errors++;
            $display("FAIL sb_then_lw: got %h, required dea5beef", rd);
        end
        run_txn(1'b0, 3'b000, 32'h12, 32'd0, rd, e, lat);
        checks++;
        if (rd !== 32'hFFFF_FFA5) begin
            errors++;
            $display("FAIL lb_sign: got %h, required ffffffa5", rd);
        end
        run_txn(1'b0, 3'b100, 32'h12, 32'd0, rd, e, lat);
        checks++;
        if (rd !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL lbu_zero: got %h, required 000000a5", rd);
        end
    endtask

    task automatic test_halfwords();
        logic [31:0] rd, mrd;
        logic e, me;
        int lat;
        run_txn(1'b1, 3'b010, 32'h14, 32'h0000_0000, rd, e, lat);
        model_op(1'b1, 3'b010, 32'h14, 32'h0000_0000, mrd, me);
        run_txn(1'b1, 3'b001, 32'h16, 32'hABCD_8001, rd, e, lat);
        model_op(1'b1, 3'b001, 32'h16, 32'hABCD_8001, mrd, me);
        run_txn(1'b0, 3'b001, 32'h16, 32'd0, rd, e, lat);
        checks++;
        if (rd !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL lh_sign: got %h, required ffff8001", rd);
        end
        run_txn(1'b0, 3'b101, 32'h16, 32'd0, rd, e, lat);
        checks++;
        if (rd !== 32'h0000_8001) begin
            errors++;
            $display("FAIL lhu_zero: got %h, required 00008001", rd);
        end
        run_txn(1'b0, 3'b010, 32'h14, 32'd0, rd, e, lat);
        checks++;
        if (rd !== 32'h8001_0000) begin
            errors++;
            $display("FAIL sh_lanes_lw: got %h, required 80010000", rd);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, mrd, exp_after;
        logic e, me, exp_err;
        int lat;
        run_txn(1'b1, 3'b010, 32'h20, 32'h1234_5678, rd, e, lat);
        model_op(1'b1, 3'b010, 32'h20, 32'h1234_5678, mrd, me);
        run_txn(1'b1, 3'b010, 32'h21, 32'h1111_1111, rd, e, lat);
        model_op(1'b1, 3'b010, 32'h21, 32'h1111_1111, mrd, me);
`ifdef DMEM_ACCESS_CHECK_EN
        exp_err = 1'b1;
        exp_after = 32'h1234_5678;
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL misaligned_rdata: got %h, required 00000000", rd);
        end
`else
        exp_err = 1'b0;
        exp_after = 32'h1111_1111;
`endif
        checks++;
        if (e !== exp_err || lat !== WC + 2) begin
            errors++;
            $display("FAIL misaligned_err: got err=%b latency=%0d, required err=%b latency=%0d",
                     e, lat, exp_err, WC + 2);
        end
        run_txn(1'b0, 3'b010, 32'h20, 32'd0, rd, e, lat);
        checks++;
        if (rd !== exp_after) begin
            errors++;
            $display("FAIL misaligned_nowrite: got %h, required %h", rd, exp_after);
        end
    endtask

    task automatic test_busy_ignored();
        logic [31:0] rd, mrd;
        logic e, me;
        int lat, pulses;
        pulses = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; func3 = 3'b010; addr = 32'h10; wdata = 32'd0;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ready) pulses++;
            if (k == 1) req = 1'b0;
            if (k == 2) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_high: got %b, required 1", busy);
                end
                req = 1'b1; we = 1'b1; wdata = 32'h0;
            end
            if (k == 3) req = 1'b0;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL busy_single_ready: got %0d pulses, required 1", pulses);
        end
        run_txn(1'b0, 3'b010, 32'h10, 32'd0, rd, e, lat);
        model_op(1'b0, 3'b010, 32'h10, 32'd0, mrd, me);
        checks++;
        if (rd !== mrd) begin
            errors++;
            $display("FAIL busy_store_dropped: got %h, required %h", rd, mrd);
        end
    endtask

    task automatic test_wraparound();
        logic [31:0] rd, mrd;
        logic e, me;
        int lat;
        run_txn(1'b1, 3'b010, 32'h400, 32'hA5A5_5A5A, rd, e, lat);
        model_op(1'b1, 3'b010, 32'h400, 32'hA5A5_5A5A, mrd, me);
        run_txn(1'b0, 3'b010, 32'h000, 32'd0, rd, e, lat);
        model_op(1'b0, 3'b010, 32'h000, 32'd0, mrd, me);
        checks++;
        if (rd !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL wraparound: got %h, required a5a55a5a", rd);
        end
    endtask

    task automatic test_back_to_back();
        int prev, pulses, exp_pulses;
        prev = -1;
        pulses = 0;
        exp_pulses = (20 - (WC + 2)) / (WC + 3) + 1;
        @(negedge clk);
        req = 1'b1; we = 1'b0; func3 = 3'b010; addr = 32'h10; wdata = 32'd0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ready) begin
                pulses++;
                checks++;
                if (rdata !== 32'hDEA5_BEEF) begin
                    errors++;
                    $display("FAIL b2b_data: got %h, required dea5beef", rdata);
                end
                if (prev >= 0) begin
                    checks++;
                    if (k - prev !== WC + 3) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d cycles, required %0d", k - prev, WC + 3);
                    end
                end
                prev = k;
            end
        end
        req = 1'b0;
        checks++;
        if (pulses !== exp_pulses) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses, required %0d", pulses, exp_pulses);
        end
        for (int n = 0; n < 32 && busy; n++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, mrd;
        logic e, me;
        int lat;
        run_txn(1'b1, 3'b010, 32'h30, 32'h0BAD_BEEF, rd, e, lat);
        model_op(1'b1, 3'b010, 32'h30, 32'h0BAD_BEEF, mrd, me);
        @(negedge clk);
        req = 1'b1; we = 1'b1; func3 = 3'b010; addr = 32'h30; wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL abort_state: busy=%b ready=%b rdata=%h, required 0 0 00000000", busy, ready, rdata);
        end
        reset = 1'b1;
        run_txn(1'b0, 3'b010, 32'h30, 32'd0, rd, e, lat);
        checks++;
        if (rd !== 32'h0BAD_BEEF) begin
            errors++;
            $display("FAIL abort_nowrite: got %h, required 0badbeef", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, a, wd;
        logic e, me, w;
        logic [2:0] f;
        int lat;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            run_txn(1'b1, 3'b010, 32'(i * 4), wd, rd, e, lat);
            model_op(1'b1, 3'b010, 32'(i * 4), wd, mrd, me);
        end
        for (int n = 0; n < 80; n++) begin
            f  = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            wd = $urandom;
            run_txn(w, f, a, wd, rd, e, lat);
            model_op(w, f, a, wd, mrd, me);
            checks++;
            if (lat !== WC + 2 || e !== me) begin
                errors++;
                $display("FAIL rand_resp #%0d we=%b f3=%b addr=%h: latency=%0d err=%b, required latency=%0d err=%b",
                         n, w, f, a, lat, e, WC + 2, me);
            end
            if (!w || me) begin
                checks++;
                if (rd !== mrd) begin
                    errors++;
                    $display("FAIL rand_rdata #%0d we=%b f3=%b addr=%h: got %h, required %h",
                             n, w, f, a, rd, mrd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_byte_lanes();
        test_halfwords();
        test_misaligned();
        test_busy_ignored();
        test_wraparound();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
